// File: rtl/truth_table_sequencer.sv
// ----------------------------------------------------------------------------
// truth_table_sequencer
// Walks every N_IN-bit input vector in ascending, descending or Gray order.
// Each vector is driven on stim for HOLD cycles. On the last cycle of each
// hold window (the check cycle) the DUT response is compared with the golden
// response. The block counts mismatches and records the first failing vector.
//
// Ports
//   clk             : clock, all state updates on the rising edge
//   rst             : synchronous active-high reset
//   start           : run request, accepted only while idle
//   mode            : order, 0/3 ascending, 1 descending, 2 Gray
//   stim            : registered vector driven to the DUT and the golden model
//   dut_o / ref_o   : DUT and golden responses to stim
//   busy            : high for the whole run
//   done            : one-cycle pulse after the last vector is checked
//   err_cnt         : saturating mismatch count for the current/last run
//   first_err_vec   : stim value of the first mismatch in the run
//   first_err_valid : first_err_vec holds a captured value
// ----------------------------------------------------------------------------
module truth_table_sequencer #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 1,
    parameter int HOLD  = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    output logic [N_IN-1:0]  stim,
    input  logic [N_OUT-1:0] dut_o,
    input  logic [N_OUT-1:0] ref_o,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_cnt,
    output logic [N_IN-1:0]  first_err_vec,
    output logic             first_err_valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0]       HOLD_LAST = 8'(HOLD - 1);
    localparam logic [N_IN-1:0]  IDX_LAST  = {N_IN{1'b1}};
    localparam logic [CNT_W-1:0] ERR_MAX   = {CNT_W{1'b1}};

    // Vector order: bitwise complement gives descending order, and
    // idx ^ (idx >> 1) gives the reflected Gray code.
    function automatic logic [N_IN-1:0] map_vec(input logic [1:0] m,
                                                input logic [N_IN-1:0] i);
        logic [N_IN-1:0] r;
        case (m)
            2'd1:    r = ~i;
            2'd2:    r = i ^ (i >> 1);
            default: r = i;
        endcase
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [N_IN-1:0]  idx_q, idx_d;
    logic [7:0]       hold_q, hold_d;
    logic [1:0]       mode_q, mode_d;
    logic [N_IN-1:0]  stim_q, stim_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [N_IN-1:0]  fev_q, fev_d;
    logic             fv_q, fv_d;

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            hold_q  <= 8'd0;
            mode_q  <= 2'd0;
            stim_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
            fev_q   <= '0;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            mode_q  <= mode_d;
            stim_q  <= stim_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fv_q    <= fv_d;
        end
    end

    // Next-state and next-output logic. busy/done/stim are computed one cycle
    // ahead so that they come straight from flops.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        mode_d  = mode_q;
        stim_d  = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;
        fev_d   = fev_q;
        fv_d    = fv_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    mode_d  = mode;
                    idx_d   = '0;
                    hold_d  = 8'd0;
                    err_d   = '0;
                    fev_d   = '0;
                    fv_d    = 1'b0;
                    stim_d  = map_vec(mode, '0);
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                busy_d = 1'b1;
                stim_d = stim_q;
                if (hold_q == HOLD_LAST) begin
                    // Responses only matter on the check cycle.
                    if (dut_o != ref_o) begin
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + CNT_W'(1);
                        end else begin
                            err_d = err_q;
                        end
                        if (!fv_q) begin
                            fev_d = stim_q;
                            fv_d  = 1'b1;
                        end else begin
                            fev_d = fev_q;
                        end
                    end else begin
                        err_d = err_q;
                    end
                    hold_d = 8'd0;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        stim_d  = '0;
                    end else begin
                        idx_d  = idx_q + N_IN'(1);
                        stim_d = map_vec(mode_q, idx_q + N_IN'(1));
                    end
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign stim            = stim_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err_cnt         = err_q;
    assign first_err_vec   = fev_q;
    assign first_err_valid = fv_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
module tb_truth_table_sequencer;

    localparam int AN = 2, AO = 1, AH = 1, AC = 8;
    localparam int BN = 3, BO = 4, BH = 3, BC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A
    logic          rst_a, start_a, busy_a, done_a, fv_a;
    logic [1:0]    mode_a;
    logic [AN-1:0] stim_a, fev_a;
    logic [AO-1:0] dut_a, ref_a;
    logic [AC-1:0] err_a;
    // Instance B
    logic          rst_b, start_b, busy_b, done_b, fv_b;
    logic [1:0]    mode_b;
    logic [BN-1:0] stim_b, fev_b;
    logic [BO-1:0] dut_b, ref_b;
    logic [BC-1:0] err_b;

    truth_table_sequencer #(.N_IN(AN), .N_OUT(AO), .HOLD(AH), .CNT_W(AC)) u_a (
        .clk(clk), .rst(rst_a), .start(start_a), .mode(mode_a), .stim(stim_a),
        .dut_o(dut_a), .ref_o(ref_a), .busy(busy_a), .done(done_a),
        .err_cnt(err_a), .first_err_vec(fev_a), .first_err_valid(fv_a));

    truth_table_sequencer #(.N_IN(BN), .N_OUT(BO), .HOLD(BH), .CNT_W(BC)) u_b (
        .clk(clk), .rst(rst_b), .start(start_b), .mode(mode_b), .stim(stim_b),
        .dut_o(dut_b), .ref_o(ref_b), .busy(busy_b), .done(done_b),
        .err_cnt(err_b), .first_err_vec(fev_b), .first_err_valid(fv_b));

    int sel = 0;
    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] o_stim, o_err, o_fev;
    logic        o_busy, o_done, o_fv;

    always_comb begin
        if (sel == 0) begin
            o_stim = 32'(stim_a); o_err = 32'(err_a); o_fev = 32'(fev_a);
            o_busy = busy_a; o_done = done_a; o_fv = fv_a;
        end else begin
            o_stim = 32'(stim_b); o_err = 32'(err_b); o_fev = 32'(fev_b);
            o_busy = busy_b; o_done = done_b; o_fv = fv_b;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s (inst %0d, t=%0t): got %0h, expected %0h", tag, sel, $time, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic [1:0] m, input logic mis);
        logic [15:0] rv;
        rv = 16'($urandom);
        if (sel == 0) begin
            rst_a = r; start_a = s; mode_a = m;
            ref_a = rv[AO-1:0];
            dut_a = mis ? ~rv[AO-1:0] : rv[AO-1:0];
        end else begin
            rst_b = r; start_b = s; mode_b = m;
            ref_b = rv[BO-1:0];
            dut_b = mis ? ~rv[BO-1:0] : rv[BO-1:0];
        end
    endtask

    task automatic check_all(input string tag, input int e_stim, input int e_busy, input int e_done,
                             input int e_err, input int e_fv, input int e_fev);
        check_eq({tag, ".stim"}, o_stim, e_stim);
        check_eq({tag, ".busy"}, 32'(o_busy), e_busy);
        check_eq({tag, ".done"}, 32'(o_done), e_done);
        check_eq({tag, ".err_cnt"}, o_err, e_err);
        check_eq({tag, ".first_err_valid"}, 32'(o_fv), e_fv);
        check_eq({tag, ".first_err_vec"}, o_fev, e_fev);
    endtask

    // mis_mode: 0 random, 1 none, 2 all cycles, 3 non-check cycles only,
    //           4 only while vector value 2 is applied
    // rst_at  : RUN cycle index at which reset is applied, -1 for none
    task automatic run_seq(input int s, input logic [1:0] m, input int mis_mode, input int rst_at);
        int n, h, cw, len, maxc, v, e, m_err, m_fv, m_fev;
        logic chk, mis;
        sel  = s;
        n    = (s == 0) ? AN : BN;
        h    = (s == 0) ? AH : BH;
        cw   = (s == 0) ? AC : BC;
        len  = 1 << n;
        maxc = (1 << cw) - 1;
        @(negedge clk);
        drive(1'b0, 1'b1, m, 1'b0);
        m_err = 0; m_fv = 0; m_fev = 0;
        for (int k = 0; k < len * h; k++) begin
            @(negedge clk);
            v = k / h;
            if (m == 2'd1)      e = len - 1 - v;
            else if (m == 2'd2) e = v ^ (v / 2);
            else                e = v;
            check_all("run", e, 1, 0, m_err, m_fv, m_fev);
            if (k == rst_at) begin
                drive(1'b1, 1'b1, m, 1'b1);
                @(negedge clk);
                check_all("after_rst", 0, 0, 0, 0, 0, 0);
                drive(1'b0, 1'b0, 2'd0, 1'b0);
                @(negedge clk);
                check_all("idle_after_rst", 0, 0, 0, 0, 0, 0);
                return;
            end
            chk = ((k % h) == (h - 1));
            case (mis_mode)
                0:       mis = ($urandom_range(0, 2) == 0);
                1:       mis = 1'b0;
                2:       mis = 1'b1;
                3:       mis = !chk;
                default: mis = (e == 2);
            endcase
            // Random start and mode during RUN must have no effect.
            drive(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), mis);
            if (chk && mis) begin
                if (m_err < maxc) m_err++;
                if (m_fv == 0) begin
                    m_fv  = 1;
                    m_fev = e;
                end
            end
        end
        @(negedge clk);
        check_all("done", 0, 0, 1, m_err, m_fv, m_fev);
        drive(1'b0, 1'b1, m, 1'b1);   // start during DONE is ignored
        @(negedge clk);
        check_all("idle_hold", 0, 0, 0, m_err, m_fv, m_fev);
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        check_all("idle_hold2", 0, 0, 0, m_err, m_fv, m_fev);
    endtask

    initial begin
        rst_a = 1'b1; start_a = 1'b1; mode_a = 2'd0; dut_a = '0; ref_a = '0;
        rst_b = 1'b1; start_b = 1'b1; mode_b = 2'd0; dut_b = '0; ref_b = '0;
        @(negedge clk);
        @(negedge clk);
        sel = 0; #1;
        check_all("reset_a", 0, 0, 0, 0, 0, 0);
        sel = 1; #1;
        check_all("reset_b", 0, 0, 0, 0, 0, 0);
        rst_a = 1'b0; start_a = 1'b0;
        rst_b = 1'b0; start_b = 1'b0;

        // Instance A: N_IN=2, HOLD=1, CNT_W=8
        run_seq(0, 2'd0, 1, -1);
        run_seq(0, 2'd2, 1, -1);
        run_seq(0, 2'd1, 1, -1);
        run_seq(0, 2'd0, 4, -1);
        run_seq(0, 2'd3, 0, -1);
        for (int i = 0; i < 6; i++) run_seq(0, 2'($urandom_range(0, 3)), 0, -1);
        run_seq(0, 2'd0, 2, 2);
        run_seq(0, 2'd0, 1, -1);

        // Instance B: N_IN=3, HOLD=3, CNT_W=2
        run_seq(1, 2'd0, 2, -1);
        run_seq(1, 2'($urandom_range(0, 3)), 3, -1);
        for (int i = 0; i < 6; i++) run_seq(1, 2'($urandom_range(0, 3)), 0, -1);
        run_seq(1, 2'd1, 0, 5);
        run_seq(1, 2'd2, 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
